// File: rtl/up_down_count_gen.sv
// up_down_count_gen: parametrised up/down event counter.
// Programmable step, runtime inclusive [min, max] bounds, synchronous clamped
// load, wrap or saturate on a boundary crossing, a registered terminal-count
// pulse and sticky overflow/underflow flags.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         count enable
//   i_up         direction: 1 = up, 0 = down
//   i_step       unsigned step magnitude, 0 = hold
//   i_load       synchronous load strobe (beats i_en)
//   i_load_val   load value, clamped into [min, max]
//   i_min_val    inclusive lower bound
//   i_max_val    inclusive upper bound
//   i_clr_flags  clears the sticky flags (a same-cycle crossing wins)
//   o_count      current count, registered
//   o_tc         one-cycle pulse after a boundary crossing, registered
//   o_ovf        sticky upward-crossing flag, registered
//   o_unf        sticky downward-crossing flag, registered
//   o_at_max     combinational: count == max
//   o_at_min     combinational: count == min
//   o_cfg_err    combinational: min > max (counter frozen)
module up_down_count_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_W   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_up,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_load_val,
    input  logic [WIDTH-1:0]  i_min_val,
    input  logic [WIDTH-1:0]  i_max_val,
    input  logic              i_clr_flags,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_tc,
    output logic              o_ovf,
    output logic              o_unf,
    output logic              o_at_max,
    output logic              o_at_min,
    output logic              o_cfg_err
);

    // Arithmetic width: one bit above the wider operand so nothing truncates.
    localparam int unsigned AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;

    logic [AW-1:0]    w_cnt_x;
    logic [AW-1:0]    w_min_x;
    logic [AW-1:0]    w_max_x;
    logic [AW-1:0]    w_step_x;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_diff;
    logic [AW-1:0]    w_floor;
    logic             w_cfg_err;
    logic             w_move;
    logic             w_up_cross;
    logic             w_dn_cross;
    logic [WIDTH-1:0] w_load_clamped;

    // Zero-extended operands.
    assign w_cnt_x  = AW'(r_count);
    assign w_min_x  = AW'(i_min_val);
    assign w_max_x  = AW'(i_max_val);
    assign w_step_x = AW'(i_step);

    assign w_sum   = w_cnt_x + w_step_x;
    assign w_diff  = w_cnt_x - w_step_x;
    // Down crossing test compares against min + step so no borrow is needed.
    assign w_floor = w_min_x + w_step_x;

    assign w_cfg_err = (i_min_val > i_max_val);

    // A real move only when enabled, not loading, bounds valid and step nonzero.
    assign w_move     = i_en & ~i_load & ~w_cfg_err & (|i_step);
    assign w_up_cross = w_move &  i_up & (w_sum > w_max_x);
    assign w_dn_cross = w_move & ~i_up & (w_cnt_x < w_floor);

    // Load value clamped into the current bounds.
    always_comb begin
        w_load_clamped = i_load_val;
        if (i_load_val < i_min_val) begin
            w_load_clamped = i_min_val;
        end else if (i_load_val > i_max_val) begin
            w_load_clamped = i_max_val;
        end
    end

    // Next-state logic.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf & ~i_clr_flags;
        w_unf_nxt   = r_unf & ~i_clr_flags;

        if (!w_cfg_err) begin
            if (i_load) begin
                w_count_nxt = w_load_clamped;
            end else if (w_up_cross) begin
                w_count_nxt = SATURATE ? i_max_val : i_min_val;
                w_tc_nxt    = 1'b1;
                w_ovf_nxt   = 1'b1;
            end else if (w_dn_cross) begin
                w_count_nxt = SATURATE ? i_min_val : i_max_val;
                w_tc_nxt    = 1'b1;
                w_unf_nxt   = 1'b1;
            end else if (w_move) begin
                // No crossing: the result lies within [0, max] and fits WIDTH.
                w_count_nxt = i_up ? WIDTH'(w_sum) : WIDTH'(w_diff);
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign o_count   = r_count;
    assign o_tc      = r_tc;
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;
    assign o_at_max  = (r_count == i_max_val);
    assign o_at_min  = (r_count == i_min_val);
    assign o_cfg_err = w_cfg_err;

endmodule

// File: tb/tb_up_down_count_gen.sv
// Bench for up_down_count_gen: a wrapping and a saturating instance share the
// stimulus; a behavioural integer model predicts both.
module tb_up_down_count_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic [3:0] step;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] min_val;
    logic [7:0] max_val;
    logic       clr_flags;

    logic [7:0] o_cnt    [2];
    logic       o_tc     [2];
    logic       o_ovf    [2];
    logic       o_unf    [2];
    logic       o_at_max [2];
    logic       o_at_min [2];
    logic       o_cfg    [2];

    int m_cnt [2];
    bit m_tc  [2];
    bit m_ovf [2];
    bit m_unf [2];

    int total = 0;
    int bad   = 0;

    up_down_count_gen #(.WIDTH(8), .STEP_W(4), .SATURATE(1'b0)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_step(step),
        .i_load(load), .i_load_val(load_val), .i_min_val(min_val),
        .i_max_val(max_val), .i_clr_flags(clr_flags),
        .o_count(o_cnt[0]), .o_tc(o_tc[0]), .o_ovf(o_ovf[0]), .o_unf(o_unf[0]),
        .o_at_max(o_at_max[0]), .o_at_min(o_at_min[0]), .o_cfg_err(o_cfg[0])
    );

    up_down_count_gen #(.WIDTH(8), .STEP_W(4), .SATURATE(1'b1)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_step(step),
        .i_load(load), .i_load_val(load_val), .i_min_val(min_val),
        .i_max_val(max_val), .i_clr_flags(clr_flags),
        .o_count(o_cnt[1]), .o_tc(o_tc[1]), .o_ovf(o_ovf[1]), .o_unf(o_unf[1]),
        .o_at_max(o_at_max[1]), .o_at_min(o_at_min[1]), .o_cfg_err(o_cfg[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the counting rules.
    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            int c  = m_cnt[i];
            int mn = int'(min_val);
            int mx = int'(max_val);
            int st = int'(step);
            m_tc[i] = 1'b0;
            if (clr_flags) begin
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
            end
            if (mn > mx) begin
                c = c;
            end else if (load) begin
                c = int'(load_val);
                if (c < mn) c = mn;
                if (c > mx) c = mx;
            end else if (en && st != 0) begin
                if (up) begin
                    if (c + st > mx) begin
                        c = (i == 1) ? mx : mn;
                        m_tc[i] = 1'b1;
                        m_ovf[i] = 1'b1;
                    end else begin
                        c = c + st;
                    end
                end else begin
                    if (c - st < mn) begin
                        c = (i == 1) ? mn : mx;
                        m_tc[i] = 1'b1;
                        m_unf[i] = 1'b1;
                    end else begin
                        c = c - st;
                    end
                end
            end
            m_cnt[i] = c;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_count[%0d]", ph, i), 32'(o_cnt[i]), 32'(m_cnt[i]));
            chk($sformatf("%s_tc[%0d]", ph, i), 32'(o_tc[i]), 32'(m_tc[i]));
            chk($sformatf("%s_ovf[%0d]", ph, i), 32'(o_ovf[i]), 32'(m_ovf[i]));
            chk($sformatf("%s_unf[%0d]", ph, i), 32'(o_unf[i]), 32'(m_unf[i]));
            chk($sformatf("%s_at_max[%0d]", ph, i), 32'(o_at_max[i]),
                32'(m_cnt[i] == int'(max_val)));
            chk($sformatf("%s_at_min[%0d]", ph, i), 32'(o_at_min[i]),
                32'(m_cnt[i] == int'(min_val)));
            chk($sformatf("%s_cfg_err[%0d]", ph, i), 32'(o_cfg[i]),
                32'(min_val > max_val));
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cyc(input string ph);
        @(posedge clk);
        if (rst_n) model_clock();
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; step = 4'd0; load = 1'b0;
        load_val = 8'd0; min_val = 8'd0; max_val = 8'd255; clr_flags = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Wrap / saturate up: min=10 max=20 from 18 step 3
        min_val = 8'd10; max_val = 8'd20; load = 1'b1; load_val = 8'd18;
        cyc("wrap_load");
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd3;
        cyc("wrap_up");
        chk("wrap_up_count", 32'(o_cnt[0]), 32'd10);
        chk("wrap_up_tc", 32'(o_tc[0]), 32'd1);
        chk("sat_up_count", 32'(o_cnt[1]), 32'd20);
        en = 1'b0;
        cyc("wrap_idle");
        chk("wrap_ovf_held", 32'(o_ovf[0]), 32'd1);

        // Saturate down: min=5 max=200 from 7 step 4, twice
        min_val = 8'd5; max_val = 8'd200; load = 1'b1; load_val = 8'd7;
        cyc("satdn_load");
        load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd4;
        cyc("satdn_1");
        chk("satdn_count1", 32'(o_cnt[1]), 32'd5);
        chk("satdn_unf", 32'(o_unf[1]), 32'd1);
        chk("wrapdn_count", 32'(o_cnt[0]), 32'd200);
        cyc("satdn_2");
        chk("satdn_count2", 32'(o_cnt[1]), 32'd5);
        chk("satdn_tc2", 32'(o_tc[1]), 32'd1);

        // Load priority over enable, clamped to max
        min_val = 8'd0; max_val = 8'd100; load = 1'b1; en = 1'b1; up = 1'b1;
        step = 4'd1; load_val = 8'd250;
        cyc("load_clamp");
        chk("load_clamp_count", 32'(o_cnt[0]), 32'd100);
        load_val = 8'd50;
        cyc("load_50");
        chk("load_50_count", 32'(o_cnt[1]), 32'd50);

        // Flag clear without and with a same-cycle crossing
        load = 1'b0; en = 1'b0; clr_flags = 1'b1;
        cyc("clr_plain");
        chk("clr_plain_ovf", 32'(o_ovf[0]), 32'd0);
        clr_flags = 1'b0; load = 1'b1; load_val = 8'd100;
        cyc("clr_load");
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1; clr_flags = 1'b1;
        cyc("clr_race");
        chk("clr_race_ovf", 32'(o_ovf[1]), 32'd1);
        clr_flags = 1'b0;

        // Invalid bounds freeze the counter
        min_val = 8'd30; max_val = 8'd20; en = 1'b1; load = 1'b1; load_val = 8'd25;
        cyc("cfg_load");
        load = 1'b0;
        cyc("cfg_en");
        chk("cfg_err_flag", 32'(o_cfg[0]), 32'd1);
        // Zero step holds
        min_val = 8'd0; max_val = 8'd200; step = 4'd0;
        cyc("step0_up");
        up = 1'b0;
        cyc("step0_dn");

        // Mid-cycle asynchronous reset from 37
        min_val = 8'd0; max_val = 8'd255; load = 1'b1; load_val = 8'd37; en = 1'b0;
        cyc("pre_rst");
        chk("pre_rst_count", 32'(o_cnt[0]), 32'd37);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst_count", 32'(o_cnt[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Below min: climbs normally, then underflows going down
        min_val = 8'd5; max_val = 8'd50; en = 1'b1; up = 1'b1; step = 4'd2;
        cyc("below_1");
        cyc("below_2");
        cyc("below_3");
        up = 1'b0; step = 4'd3;
        cyc("below_dn");

        // Randomised phase
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int a = int'($urandom_range(0, 255));
                int b = int'($urandom_range(0, 255));
                if (a > b && $urandom_range(0, 9) != 0) begin
                    int t = a; a = b; b = t;
                end
                min_val = 8'(a);
                max_val = 8'(b);
            end
            en        = ($urandom_range(0, 9) < 8);
            up        = 1'($urandom_range(0, 1));
            step      = 4'($urandom_range(0, 15));
            load      = ($urandom_range(0, 9) == 0);
            load_val  = 8'($urandom_range(0, 255));
            clr_flags = ($urandom_range(0, 9) == 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_down_count_gen.md
# up_down_count_gen

Parametrised up/down counter: the next generation of the team's basic up/down counter. Adds configurable width, programmable step, runtime min/max bounds, synchronous load, wrap or saturate on boundary crossing, a terminal-count pulse and sticky overflow/underflow flags. It sits under the same `intf`-style bench as a drop-in timing/event counter for larger blocks.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- STEP_W, 4, width of the step input
- SATURATE, 0, 0 = wrap on boundary crossing, 1 = clamp at boundary
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable
- up  in  1  direction: 1 = up, 0 = down
- step  in  STEP_W  increment/decrement magnitude, unsigned; 0 = hold
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value for load
- min_val  in  WIDTH  lower bound, unsigned, inclusive
- max_val  in  WIDTH  upper bound, unsigned, inclusive
- clr_flags  in  1  clears ovf/unf
- count  out  WIDTH  current count, registered
- tc  out  1  one-cycle pulse on a boundary crossing, registered
- ovf  out  1  sticky: an upward crossing of max_val occurred
- unf  out  1  sticky: a downward crossing of min_val occurred
- at_max  out  1  combinational: count == max_val
- at_min  out  1  combinational: count == min_val
- cfg_err  out  1  combinational: min_val > max_val

## Operation
- Reset (rst = 0, asynchronous): count = 0, tc = 0, ovf = 0, unf = 0. at_max/at_min/cfg_err follow inputs and count.
- cfg_err = 1: load and en ignored, count holds, tc = 0; clr_flags still works.
- Priority per cycle: load > en > hold.
- Load: count <= load_val clamped to [min_val, max_val]; no tc, no flag change.
- Arithmetic in WIDTH+1 bits, step zero-extended; no intermediate truncation.
- Up (en=1, up=1): sum = count + step. If sum > max_val: crossing. Else count <= sum.
- Down (en=1, up=0): if count < min_val + step (WIDTH+1 bits): crossing. Else count <= count − step.
- Up crossing: SATURATE=0 -> count <= min_val; SATURATE=1 -> count <= max_val. Next cycle tc = 1, ovf = 1.
- Down crossing: SATURATE=0 -> count <= max_val; SATURATE=1 -> count <= min_val. Next cycle tc = 1, unf = 1.
- Wrap discards excess (no modulo carry of remainder).
- Saturate already at bound and stepping outward still counts as a crossing: tc pulses every such cycle, flag set.
- step = 0 with en = 1: count holds, no crossing, tc = 0.
- count below min_val (e.g. after reset with min_val > 0) counting up: normal increments until ≥ min_val; counting down: underflow crossing.
- clr_flags = 1 clears ovf and unf; a crossing in the same cycle wins (flag set).
- tc = 0 in every cycle without a crossing.

## Timing
- count, tc, ovf, unf update on the rising clk edge after the qualifying inputs are sampled: latency 1 cycle.
- tc is high exactly one cycle per crossing; back-to-back crossings give tc high on consecutive cycles.
- at_max, at_min, cfg_err: zero-latency, combinational from count and bounds.
- rst assertion mid-count forces reset values immediately, independent of clk; deassertion is synchronised by the environment; first count change on the first rising edge with rst = 1.
- min_val/max_val may change any cycle; the new values take effect for the same cycle's evaluation.

## Test plan
- Reset: count at 37, assert rst mid-cycle -> count = 0, tc/ovf/unf = 0 before next edge.
- Wrap up, WIDTH=8, SATURATE=0, min=10, max=20, count=18, step=3, up -> next count = 10, tc = 1 one cycle, ovf = 1 held, unf = 0.
- Saturate down, SATURATE=1, min=5, max=200, count=7, step=4, down -> count = 5, tc = 1, unf = 1; next cycle same inputs -> count = 5, tc = 1 again.
- Load priority: load = 1, en = 1, load_val = 250, max = 100 -> count = 100, tc = 0, flags unchanged; load_val = 50 -> count = 50.
- Flag clear race: ovf = 1, clr_flags = 1 with no crossing -> ovf = 0; clr_flags = 1 with an up crossing same cycle -> ovf = 1.
- cfg_err: min=30, max=20 -> cfg_err = 1, en/load with step 1 leave count unchanged, tc = 0; step = 0 with valid bounds -> count holds, tc = 0.
